change_dispense_scheduler: RTL and testbench

Sequences the coin-return dispenser of the vending machine. It keeps per-tube coin inventories for the five denominations: B = 100, Q = 25, D = 10, N = 5 and P = 1 cents. For a requested change amount, it issues one coin request at a time to the dispenser mechanism over a req/ack handshake, choosing denominations greedily. It reports completion, shortfall and the undelivered remainder to the vend controller.

---
 rtl/change_dispense_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_change_dispense_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_scheduler.sv
// change_dispense_scheduler
//
// Sequences the coin-return dispenser. Five tube inventories (B=100, Q=25,
// D=10, N=5, P=1 cents) are kept locally. For a requested change amount the
// block issues one coin request at a time over a disp_req/disp_ack handshake,
// always picking the largest coin that fits the remainder and is in stock,
// then reports completion, shortfall and the undelivered remainder.
//
// Optional feature macro: EXACT_CHANGE_CHECK_EN
//   When defined, a 5-cycle CHECK state does a greedy dry run on shadow
//   copies of the remainder and counts before anything is dispensed; if exact
//   change is impossible the transaction ends immediately with nothing paid.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start, amount           transaction request (sampled only when idle)
//   refill_valid/sel/count  add coins to one tube (0=B 1=Q 2=D 3=N 4=P)
//   disp_req, disp_sel      coin request and denomination to the dispenser
//   disp_ack                dispenser ejected the requested coin
//   avail_B..avail_P        registered "tube not empty" flags
//   busy, done              not idle / one-cycle end-of-transaction pulse
//   short, remaining        shortfall flag and undelivered cents
module change_dispense_scheduler #(
   parameter int AMT_W    = 9,
   parameter int CNT_W    = 8,
   parameter int INIT_CNT = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             refill_valid,
   input  logic [2:0]       refill_sel,
   input  logic [CNT_W-1:0] refill_count,
   output logic             disp_req,
   output logic [2:0]       disp_sel,
   input  logic             disp_ack,
   output logic             avail_B,
   output logic             avail_Q,
   output logic             avail_D,
   output logic             avail_N,
   output logic             avail_P,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining
);

   localparam int NUM_TUBES = 5;

   typedef enum logic [2:0] {
      IDLE,
`ifdef EXACT_CHANGE_CHECK_EN
      CHECK,
`endif
      SELECT,
      DISPENSE,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] rem_q;
   logic [CNT_W-1:0] count_q [NUM_TUBES];
   logic [CNT_W-1:0] count_d [NUM_TUBES];
   logic [CNT_W:0]   cnt_sum [NUM_TUBES];
   logic [NUM_TUBES-1:0] avail_q;
   logic             pick_found;
   logic [2:0]       pick_sel;
   logic [2:0]       disp_sel_q;
   logic             short_q;
   logic [AMT_W-1:0] remaining_q;

   function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] sel);
      case (sel)
         3'd0:    return AMT_W'(100);
         3'd1:    return AMT_W'(25);
         3'd2:    return AMT_W'(10);
         3'd3:    return AMT_W'(5);
         3'd4:    return AMT_W'(1);
         default: return '0;
      endcase
   endfunction

`ifdef EXACT_CHANGE_CHECK_EN
   logic [2:0]       chk_idx_q;
   logic [AMT_W-1:0] sh_rem_q;
   logic [CNT_W-1:0] sh_cnt_q [NUM_TUBES];
   logic [AMT_W-1:0] chk_rem_next;

   // One greedy step of the dry run: take as many coins of this denomination
   // as fit, limited by the shadow count. Divisors are constants per branch.
   function automatic logic [AMT_W-1:0] greedy_step(input logic [2:0] idx,
                                                     input logic [AMT_W-1:0] r,
                                                     input logic [CNT_W-1:0] c);
      int unsigned v;
      int unsigned q;
      v = 32'(coin_value(idx));
      case (idx)
         3'd0:    q = 32'(r) / 100;
         3'd1:    q = 32'(r) / 25;
         3'd2:    q = 32'(r) / 10;
         3'd3:    q = 32'(r) / 5;
         default: q = 32'(r);
      endcase
      if (q > 32'(c)) q = 32'(c);
      return r - AMT_W'(q * v);
   endfunction

   assign chk_rem_next = greedy_step(chk_idx_q, sh_rem_q, sh_cnt_q[chk_idx_q]);
`endif

   // Greedy pick: scan from the smallest coin upward so the last hit, the
   // largest in-stock coin not exceeding the remainder, wins. A zero
   // remainder never matches, which is how SELECT recognises completion.
   always_comb begin
      pick_found = 1'b0;
      pick_sel   = 3'd0;
      for (int i = NUM_TUBES - 1; i >= 0; i--) begin
         if (count_q[i] != '0 && coin_value(3'(i)) <= rem_q) begin
            pick_found = 1'b1;
            pick_sel   = 3'(i);
         end
      end
   end

   // Next tube counts: refill and dispense decrement combine in one sum that
   // is one bit wider, so a simultaneous refill and decrement on the same tube
   // gives count - 1 + refill, saturated at all-ones.
   always_comb begin
      for (int i = 0; i < NUM_TUBES; i++) begin
         cnt_sum[i] = {1'b0, count_q[i]}
                    + ((refill_valid && refill_sel == 3'(i)) ? {1'b0, refill_count} : '0)
                    - ((state_q == DISPENSE && disp_ack && disp_sel_q == 3'(i))
                       ? (CNT_W+1)'(1) : '0);
         count_d[i] = cnt_sum[i][CNT_W] ? '1 : cnt_sum[i][CNT_W-1:0];
      end
   end

   // Inventory and availability flags. The flags follow the counters one
   // cycle late so they are clean registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_TUBES; i++) count_q[i] <= CNT_W'(INIT_CNT);
         avail_q <= (INIT_CNT != 0) ? '1 : '0;
      end else begin
         for (int i = 0; i < NUM_TUBES; i++) begin
            count_q[i] <= count_d[i];
            avail_q[i] <= (count_q[i] != '0);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic. Outputs are decoded straight from the state register
   // below, so a reset mid-dispense drops disp_req without waiting for a clock.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef EXACT_CHANGE_CHECK_EN
               state_d = CHECK;
`else
               state_d = SELECT;
`endif
            end
         end
`ifdef EXACT_CHANGE_CHECK_EN
         CHECK: begin
            if (chk_idx_q == 3'd4) state_d = (chk_rem_next != '0) ? DONE : SELECT;
         end
`endif
         SELECT:   state_d = pick_found ? DISPENSE : DONE;
         DISPENSE: if (disp_ack) state_d = SELECT;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Transaction datapath. The result (remaining/short) is loaded on the edge
   // entering DONE so it is already valid while done is high, and then held
   // until the next transaction finishes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q       <= '0;
         disp_sel_q  <= 3'd0;
         short_q     <= 1'b0;
         remaining_q <= '0;
`ifdef EXACT_CHANGE_CHECK_EN
         chk_idx_q   <= 3'd0;
         sh_rem_q    <= '0;
         for (int i = 0; i < NUM_TUBES; i++) sh_cnt_q[i] <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  rem_q   <= amount;
                  short_q <= 1'b0;
`ifdef EXACT_CHANGE_CHECK_EN
                  chk_idx_q <= 3'd0;
                  sh_rem_q  <= amount;
                  for (int i = 0; i < NUM_TUBES; i++) sh_cnt_q[i] <= count_q[i];
`endif
               end
            end
`ifdef EXACT_CHANGE_CHECK_EN
            CHECK: begin
               chk_idx_q <= chk_idx_q + 3'd1;
               sh_rem_q  <= chk_rem_next;
               if (chk_idx_q == 3'd4 && chk_rem_next != '0) begin
                  remaining_q <= rem_q;
                  short_q     <= 1'b1;
               end
            end
`endif
            SELECT: begin
               if (pick_found) begin
                  disp_sel_q <= pick_sel;
               end else begin
                  remaining_q <= rem_q;
                  short_q     <= (rem_q != '0);
               end
            end
            DISPENSE: begin
               if (disp_ack) rem_q <= rem_q - coin_value(disp_sel_q);
            end
            default: ;
         endcase
      end
   end

   assign disp_req  = (state_q == DISPENSE);
   assign disp_sel  = disp_sel_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign short     = short_q;
   assign remaining = remaining_q;
   assign avail_B   = avail_q[0];
   assign avail_Q   = avail_q[1];
   assign avail_D   = avail_q[2];
   assign avail_N   = avail_q[3];
   assign avail_P   = avail_q[4];

endmodule

// File: tb/tb_change_dispense_scheduler.sv
// Testbench for change_dispense_scheduler. Directed transactions push the
// expected coin sequence and final result into queues; a monitor pops and
// compares them whenever the DUT raises disp_req or done. A responder model
// plays the dispenser with a programmable acknowledge delay.
module tb_change_dispense_scheduler;

   localparam int AMT_W = 9;
   localparam int CNT_W = 8;
`ifdef EXACT_CHANGE_CHECK_EN
   localparam int ZERO_LAT = 7;
`else
   localparam int ZERO_LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [AMT_W-1:0] amount = '0;
   logic             refill_valid = 1'b0;
   logic [2:0]       refill_sel = 3'd0;
   logic [CNT_W-1:0] refill_count = '0;
   logic             disp_ack = 1'b0;
   logic             disp_req;
   logic [2:0]       disp_sel;
   logic             avail_B, avail_Q, avail_D, avail_N, avail_P;
   logic             busy, done, short;
   logic [AMT_W-1:0] remaining;

   int checks = 0;
   int passed = 0;
   int ack_delay = 0;

   logic [2:0]     coin_q[$];
   logic [AMT_W:0] result_q[$];

   always #5 clk = ~clk;

   change_dispense_scheduler #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_CNT(0)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .amount(amount),
      .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_count(refill_count),
      .disp_req(disp_req), .disp_sel(disp_sel), .disp_ack(disp_ack),
      .avail_B(avail_B), .avail_Q(avail_Q), .avail_D(avail_D),
      .avail_N(avail_N), .avail_P(avail_P),
      .busy(busy), .done(done), .short(short), .remaining(remaining)
   );

   task automatic checkOutput(input string name, input int unsigned actual,
                              input int unsigned expected);
      checks++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Dispenser model: acknowledges each request after ack_delay idle cycles.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (disp_req && !disp_ack) begin
            if (wait_cnt >= ack_delay) begin
               disp_ack = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            disp_ack = 1'b0;
            if (!disp_req) wait_cnt = 0;
         end
      end
   end

   // Monitor: every new coin request and every done pulse consumes one
   // expected entry from the scoreboard.
   initial begin
      logic           prev_req;
      logic [2:0]     exp_coin;
      logic [AMT_W:0] exp_res;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (disp_req && !prev_req) begin
            if (coin_q.size() == 0) begin
               checkOutput("unexpected disp_req", disp_req, 0);
            end else begin
               exp_coin = coin_q.pop_front();
               checkOutput("coin order", disp_sel, exp_coin);
            end
         end
         prev_req = disp_req;
         if (done) begin
            if (result_q.size() == 0) begin
               checkOutput("unexpected done", done, 0);
            end else begin
               exp_res = result_q.pop_front();
               checkOutput("done short", short, exp_res[AMT_W]);
               checkOutput("done remaining", remaining, exp_res[AMT_W-1:0]);
            end
         end
      end
   end

   task automatic doReset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic refill(input logic [2:0] sel, input int cnt);
      @(negedge clk);
      refill_valid = 1'b1;
      refill_sel   = sel;
      refill_count = CNT_W'(cnt);
      @(negedge clk);
      refill_valid = 1'b0;
   endtask

   task automatic applyStimulus(input int amt);
      @(negedge clk);
      start  = 1'b1;
      amount = AMT_W'(amt);
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic pushResult(input logic s, input int rem);
      result_q.push_back({s, AMT_W'(rem)});
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!done) checkOutput("done timeout", done, 1);
   endtask

   task automatic waitReq();
      int n;
      n = 0;
      while (!disp_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!disp_req) checkOutput("disp_req timeout", disp_req, 1);
   endtask

   function automatic int availVec();
      return int'({avail_B, avail_Q, avail_D, avail_N, avail_P});
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int stable;

      // Reset state
      doReset();
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset disp_req", disp_req, 0);
      checkOutput("reset disp_sel", disp_sel, 0);
      checkOutput("reset short", short, 0);
      checkOutput("reset remaining", remaining, 0);
      checkOutput("reset avail", availVec(), 0);

      // B1 Q2 D1 N0 P3, amount 138 -> B Q D P P P, exact
      refill(3'd0, 1);
      refill(3'd1, 2);
      refill(3'd2, 1);
      refill(3'd4, 3);
      repeat (2) @(negedge clk);
      checkOutput("avail after refill", availVec(), 5'b11101);
      coin_q.push_back(3'd0); coin_q.push_back(3'd1); coin_q.push_back(3'd2);
      coin_q.push_back(3'd4); coin_q.push_back(3'd4); coin_q.push_back(3'd4);
      pushResult(1'b0, 0);
      applyStimulus(138);
      waitDone();
      @(negedge clk);
      checkOutput("avail after 138", availVec(), 5'b01000);
      checkOutput("idle after 138", busy, 0);

      // Q1 P3, amount 41 -> partial (or refused with exact-change check)
      refill(3'd4, 3);
`ifdef EXACT_CHANGE_CHECK_EN
      pushResult(1'b1, 41);
`else
      coin_q.push_back(3'd1);
      coin_q.push_back(3'd4); coin_q.push_back(3'd4); coin_q.push_back(3'd4);
      pushResult(1'b1, 13);
`endif
      applyStimulus(41);
      waitDone();
      repeat (2) @(negedge clk);
`ifdef EXACT_CHANGE_CHECK_EN
      checkOutput("avail after 41", availVec(), 5'b01001);
`else
      checkOutput("avail after 41", availVec(), 5'b00000);
`endif
      checkOutput("short held", short, 1);

      // Zero amount: done after fixed latency, no coin
      doReset();
      pushResult(1'b0, 0);
      applyStimulus(0);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("zero amount latency", n, ZERO_LAT - 1);
      @(negedge clk);

      // Held-off acknowledge: request stays stable, exactly one decrement
      ack_delay = 7;
      refill(3'd2, 2);
      coin_q.push_back(3'd2);
      pushResult(1'b0, 0);
      applyStimulus(10);
      waitReq();
      stable = 0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         if (disp_req && disp_sel == 3'd2) stable++;
      end
      checkOutput("req hold cycles", stable, 7);
      waitDone();
      ack_delay = 0;
      @(negedge clk);
      checkOutput("D left after one coin", avail_D, 1);
      coin_q.push_back(3'd2);
      pushResult(1'b0, 0);
      applyStimulus(10);
      waitDone();
      repeat (2) @(negedge clk);
      checkOutput("D empty after two coins", avail_D, 0);

      // Refill and decrement of P in the same cycle; start while busy ignored
      refill(3'd4, 1);
      coin_q.push_back(3'd4);
      pushResult(1'b0, 0);
      applyStimulus(1);
      waitReq();
      refill_valid = 1'b1;
      refill_sel   = 3'd4;
      refill_count = CNT_W'(5);
      start        = 1'b1;
      amount       = AMT_W'(100);
      @(negedge clk);
      refill_valid = 1'b0;
      start        = 1'b0;
      waitDone();
      repeat (4) @(negedge clk);
      checkOutput("idle after busy start", busy, 0);
      checkOutput("P available after collision", avail_P, 1);
`ifdef EXACT_CHANGE_CHECK_EN
      pushResult(1'b1, 6);
`else
      for (int i = 0; i < 5; i++) coin_q.push_back(3'd4);
      pushResult(1'b1, 1);
`endif
      applyStimulus(6);
      waitDone();
      @(negedge clk);

      // Reset while a request is outstanding
      ack_delay = 50;
      refill(3'd2, 1);
      coin_q.push_back(3'd2);
      applyStimulus(10);
      waitReq();
      reset_n = 1'b0;
      #1;
      checkOutput("req drops on reset", disp_req, 0);
      checkOutput("busy drops on reset", busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ack_delay = 0;
      repeat (2) @(negedge clk);
      checkOutput("post-reset done", done, 0);
      checkOutput("post-reset busy", busy, 0);
      checkOutput("post-reset avail", availVec(), 0);
      checkOutput("post-reset remaining", remaining, 0);

      repeat (3) @(negedge clk);
      checkOutput("coins left in scoreboard", coin_q.size(), 0);
      checkOutput("results left in scoreboard", result_q.size(), 0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
